qsn_right_pipe: RTL and testbench

// - Right-hand half of the QC-LDPC quasi-cyclic shift network (QSN). It complements the left shifter,

---
 rtl/qsn_right_pipe_if.sv | 26 ++
 rtl/qsn_right_pipe.sv | 88 ++++++++
 tb/tb_qsn_right_pipe.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/qsn_right_pipe_if.sv
// Handshake and data bundle between the QSN right shifter and its producer/consumer.
// master drives beats in and accepts results; slave is the shifter itself.
interface qsn_right_pipe_if #(
    parameter int LEN   = 17,
    parameter int SEL_W = 5,
    parameter int MSG_W = 1
);
    logic                        in_valid;
    logic                        in_ready;
    logic [(LEN-1)*MSG_W-1:0]    sw_in;
    logic [SEL_W-1:0]            sel;
    logic                        out_valid;
    logic                        out_ready;
    logic [(LEN-1)*MSG_W-1:0]    sw_out;
    logic                        sel_err;

    modport master (
        output in_valid, sw_in, sel, out_ready,
        input  in_ready, out_valid, sw_out, sel_err
    );

    modport slave (
        input  in_valid, sw_in, sel, out_ready,
        output in_ready, out_valid, sw_out, sel_err
    );
endinterface

// File: rtl/qsn_right_pipe.sv
// Right half of the QC-LDPC quasi-cyclic shift network: lanes 0..s-1 land on final positions
// LEN-s..LEN-1 through a two-stage (coarse by 4, fine by 0..3) elastic pipeline.
module qsn_right_pipe #(
    parameter int LEN   = 17,
    parameter int SEL_W = 5,
    parameter int MSG_W = 1
) (
    input  logic             sys_clk,
    input  logic             rstn,
    qsn_right_pipe_if.slave  pipe
);
    localparam int unsigned NL    = LEN - 1;   // output lanes (final positions 1..LEN-1)
    localparam int unsigned AL    = NL + 3;    // stage A keeps 3 extra lanes for the fine shift
    localparam int unsigned WL    = 2 * NL;    // source viewed as in << NL lanes
    localparam int unsigned LEN_U = LEN;

    logic                    v_a;
    logic                    v_b;
    logic [AL*MSG_W-1:0]     data_a;
    logic [1:0]              fine_a;
    logic                    err_a;
    logic [NL*MSG_W-1:0]     data_b;
    logic                    err_b;

    logic                    adv_a;
    logic                    adv_b;
    logic                    sel_bad;
    logic [AL*MSG_W-1:0]     coarse;
    logic [NL*MSG_W-1:0]     fine;
    int unsigned             c_shift;
    int unsigned             c_src;

    assign adv_b         = pipe.out_ready || !v_b;
    assign adv_a         = adv_b || !v_a;
    assign pipe.in_ready = adv_a && rstn;
    assign sel_bad       = 32'(pipe.sel) >= LEN_U;

    // out[k] = w[k+s] with w = in << NL lanes; this stage applies the multiple-of-4 part of s
    always_comb begin
        coarse  = '0;
        c_src   = '0;
        c_shift = 32'(pipe.sel[SEL_W-1:2]) << 2;
        for (int unsigned j = 0; j < AL; j++) begin
            c_src = j + c_shift;
            if (!sel_bad && c_src >= NL && c_src < WL)
                coarse[j*MSG_W +: MSG_W] = pipe.sw_in[(c_src-NL)*MSG_W +: MSG_W];
        end
    end

    always_comb begin
        fine = '0;
        for (int unsigned k = 0; k < NL; k++)
            fine[k*MSG_W +: MSG_W] = data_a[(k + 32'(fine_a))*MSG_W +: MSG_W];
    end

    // Payload registers load only with a valid beat so bubbles leave sw_out untouched
    always_ff @(posedge sys_clk) begin
        if (!rstn) begin
            v_a    <= 1'b0;
            v_b    <= 1'b0;
            data_a <= '0;
            fine_a <= '0;
            err_a  <= 1'b0;
            data_b <= '0;
            err_b  <= 1'b0;
        end else begin
            if (adv_a) begin
                v_a <= pipe.in_valid;
                if (pipe.in_valid) begin
                    data_a <= coarse;
                    fine_a <= pipe.sel[1:0];
                    err_a  <= sel_bad;
                end
            end
            if (adv_b) begin
                v_b <= v_a;
                if (v_a) begin
                    data_b <= fine;
                    err_b  <= err_a;
                end
            end
        end
    end

    assign pipe.out_valid = v_b;
    assign pipe.sw_out    = data_b;
    assign pipe.sel_err   = err_b;
endmodule

// File: tb/tb_qsn_right_pipe.sv
// Bench for qsn_right_pipe: directed vectors, random traffic and backpressure checked against a
// full-rotation reference merged with a left-shifter model.
module tb_qsn_right_pipe;
    localparam int LEN   = 17;
    localparam int SEL_W = 5;
    localparam int MSG_W = 1;
    localparam int W     = (LEN-1)*MSG_W;

    logic sys_clk = 1'b0;
    logic rstn    = 1'b0;

    qsn_right_pipe_if #(.LEN(LEN), .SEL_W(SEL_W), .MSG_W(MSG_W)) bus ();

    qsn_right_pipe #(.LEN(LEN), .SEL_W(SEL_W), .MSG_W(MSG_W)) dut (
        .sys_clk (sys_clk),
        .rstn    (rstn),
        .pipe    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [LEN-1:0] full;
        int             s;
        int             acc;
        bit             chk_lat;
        bit             has_lit;
        logic [W-1:0]   lit;
    } beat_t;

    beat_t          sb[$];
    int             checks = 0;
    int             errors = 0;
    int             cyc    = 0;
    int             pops   = 0;
    bit             lat_chk = 1'b0;
    bit             stalled = 1'b0;
    bit             accepted;
    logic [W-1:0]   held_out;
    logic           held_err;
    logic [LEN-1:0] cur_full = '0;
    bit             cur_has_lit = 1'b0;
    logic [W-1:0]   cur_lit = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full cyclic left rotation: final[i] = in[(i+s) mod LEN]
    function automatic logic [LEN-1:0] rotate(input logic [LEN-1:0] full, input int s);
        logic [LEN-1:0] r;
        for (int i = 0; i < LEN; i++) r[i] = full[(i + s) % LEN];
        return r;
    endfunction

    // Right half: final position p (lane p-1) is wrapped content when p >= LEN-s
    function automatic logic [W-1:0] model_right(input logic [LEN-1:0] full, input int s);
        logic [W-1:0] r;
        r = '0;
        if (s > 0 && s < LEN)
            for (int p = 1; p < LEN; p++)
                if (p >= LEN - s) r[p-1] = full[(p + s) % LEN];
        return r;
    endfunction

    // Left shifter covers positions below LEN-s, the right half supplies the rest
    function automatic logic [LEN-1:0] merge(input logic [LEN-1:0] full, input int s,
                                             input logic [W-1:0] right);
        logic [LEN-1:0] m;
        for (int p = 0; p < LEN; p++)
            m[p] = (p < LEN - s) ? full[p + s] : right[p-1];
        return m;
    endfunction

    // One clock: drive at negedge, sample just after, state advances at the next posedge
    task automatic cycle(input bit rs, input bit iv, input int s, input bit ordy);
        beat_t b;
        @(negedge sys_clk);
        rstn          = rs;
        bus.in_valid  = iv;
        bus.sw_in     = cur_full[W-1:0];
        bus.sel       = SEL_W'(s);
        bus.out_ready = ordy;
        #1;
        if (stalled) begin
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_data", 32'(bus.sw_out), 32'(held_out));
            check("hold_err", 32'(bus.sel_err), 32'(held_err));
        end
        if (bus.out_valid === 1'b1 && ordy) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 32'(bus.out_valid), 32'd0);
            end else begin
                b = sb.pop_front();
                pops++;
                check("sw_out", 32'(bus.sw_out), 32'(model_right(b.full, b.s)));
                check("sel_err", 32'(bus.sel_err), 32'(b.s >= LEN));
                if (b.has_lit) check("vector", 32'(bus.sw_out), 32'(b.lit));
                if (b.s < LEN)
                    check("merged_rotation", 32'(merge(b.full, b.s, bus.sw_out)),
                          32'(rotate(b.full, b.s)));
                if (b.chk_lat) check("latency", 32'(cyc - b.acc), 32'd2);
            end
        end
        stalled  = rs && (bus.out_valid === 1'b1) && !ordy;
        held_out = bus.sw_out;
        held_err = bus.sel_err;
        accepted = iv && (bus.in_ready === 1'b1);
        if (accepted) begin
            b.full    = cur_full;
            b.s       = s;
            b.acc     = cyc;
            b.chk_lat = lat_chk;
            b.has_lit = cur_has_lit;
            b.lit     = cur_lit;
            sb.push_back(b);
        end
        cyc++;
    endtask

    task automatic beat(input logic [W-1:0] in16, input int s, input bit has_lit,
                        input logic [W-1:0] lit);
        cur_full    = {1'($urandom), in16};
        cur_has_lit = has_lit;
        cur_lit     = lit;
        cycle(1'b1, 1'b1, s, 1'b1);
        check("accept", 32'(accepted), 32'd1);
        cur_has_lit = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) cycle(1'b1, 1'b0, 0, 1'b1);
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int bs[4];
        logic [LEN-1:0] bd[4];
        int idx;
        int pops0;

        bus.in_valid  = 1'b0;
        bus.sw_in     = '0;
        bus.sel       = '0;
        bus.out_ready = 1'b1;

        // Reset state
        cycle(1'b0, 1'b0, 0, 1'b1);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        cycle(1'b0, 1'b1, 0, 1'b1);
        check("rst_in_ready2", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sw_out", 32'(bus.sw_out), 32'd0);
        check("rst_sel_err", 32'(bus.sel_err), 32'd0);

        // Directed vectors
        lat_chk = 1'b1;
        beat(16'h0001, 1, 1'b1, 16'h8000);
        cycle(1'b1, 1'b0, 0, 1'b1);
        check("lat_not_1", 32'(bus.out_valid), 32'd0);
        drain();
        beat(16'hA5C3, 16, 1'b1, 16'hA5C3);
        beat(16'hA5C3, 0,  1'b1, 16'h0000);
        beat(16'hFFFF, 17, 1'b1, 16'h0000);
        beat(16'h000F, 4,  1'b1, 16'hF000);
        drain();

        // Sweep every legal shift back-to-back
        for (int s = 0; s < LEN; s++) beat(16'($urandom), s, 1'b0, '0);
        drain();

        // Random traffic with random stalls and out-of-range shifts
        lat_chk = 1'b0;
        for (int i = 0; i < 300; i++) begin
            cur_full = LEN'($urandom);
            cycle(1'b1, 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 31)),
                  1'($urandom_range(0, 2) != 0));
        end
        drain();

        // Backpressure: 4 beats, out_ready low for cycles 2..5
        for (int i = 0; i < 4; i++) begin
            bs[i] = int'($urandom_range(1, 16));
            bd[i] = LEN'($urandom);
        end
        idx   = 0;
        pops0 = pops;
        for (int c = 1; c <= 30 && (idx < 4 || sb.size() > 0); c++) begin
            cur_full = (idx < 4) ? bd[idx] : '0;
            cycle(1'b1, idx < 4, (idx < 4) ? bs[idx] : 0, !(c >= 2 && c <= 5));
            if (c == 3) check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
            if (c == 5) check("bp_held_two", 32'(sb.size()), 32'd2);
            if (accepted) idx++;
        end
        check("bp_all_out", 32'(pops - pops0), 32'd4);
        check("bp_empty", 32'(sb.size()), 32'd0);

        // Reset with two beats in flight
        lat_chk = 1'b1;
        beat(16'($urandom), 3, 1'b0, '0);
        beat(16'($urandom), 9, 1'b0, '0);
        cycle(1'b0, 1'b0, 0, 1'b0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        sb.delete();
        cur_full = LEN'($urandom);
        cycle(1'b1, 1'b1, 7, 1'b1);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_sw_out", 32'(bus.sw_out), 32'd0);
        check("post_rst_accept", 32'(accepted), 32'd1);
        cycle(1'b1, 1'b0, 0, 1'b1);
        check("post_rst_lat_not_1", 32'(bus.out_valid), 32'd0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
